hs32_memarb: RTL and testbench
==============================

HS32_MEMARB -- requirements
Module: hs32_memarb

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requesting channels, legal range 2..8.
REQ-002 SHALL have parameter RR, default 0, arbitration mode: 0 = fixed priority with lowest index winning, 1 = round-robin.
REQ-003 SHALL have parameter TIMEOUT, default 0, maximum BUSY cycles awaiting done; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port addr_ch, input, NCH*32 bits: per-channel address; channel i occupies bits [32i+31:32i].
REQ-007 SHALL have port dtw_ch, input, NCH*32 bits: per-channel write data, packed the same as addr_ch.
REQ-008 SHALL have port rw_ch, input, NCH bits: per-channel direction, 1 = write, 0 = read.
REQ-009 SHALL have port req_ch, input, NCH bits: per-channel request level.
REQ-010 SHALL have port ack_ch, output, NCH bits: per-channel one-cycle completion pulse.
REQ-011 SHALL have port dtr, output, 32 bits: read data shared by all channels, valid while ack is high.
REQ-012 SHALL have port err, output, 1 bit: high together with ack when the transaction timed out.
REQ-013 SHALL have port addr, output, 32 bits: external bus address.
REQ-014 SHALL have port rw, output, 1 bit: external bus direction.
REQ-015 SHALL have port dout, output, 32 bits: external bus write data.
REQ-016 SHALL have port valid, output, 1 bit: external request.
REQ-017 SHALL have port din, input, 32 bits: external read data.
REQ-018 SHALL have port done, input, 1 bit: external completion strobe.

Function
REQ-019 SHALL be a three-state FSM with states IDLE, BUSY and ACK; all outputs SHALL be registered.
REQ-020 In IDLE with any req_ch bit high, SHALL select a grant index g, latch addr, rw and dout from channel g, set valid=1 and enter BUSY on the same edge; valid is therefore high in the cycle after req is first sampled.
REQ-021 With RR=0, g SHALL be the lowest set index; with RR=1, g SHALL be the first set index searching upward from last+1, wrapping modulo NCH, where last is the most recently granted index.
REQ-022 In BUSY, addr, rw, dout and valid SHALL hold stable; changes on channel inputs SHALL be ignored, including req_ch[g] falling, and the transaction SHALL still complete.
REQ-023 In BUSY with done=1, SHALL capture dtr<=din when rw=0 (dtr unchanged for writes), clear valid, set ack_ch[g]=1, set err=0 and enter ACK.
REQ-024 With TIMEOUT>0, a cycle counter SHALL clear on BUSY entry; when it reaches TIMEOUT with done still 0, SHALL clear valid, set ack_ch[g]=1, set err=1, leave dtr unchanged and enter ACK; done arriving on that same cycle takes precedence, giving a normal completion.
REQ-025 ACK SHALL last exactly one cycle, then ack_ch and err clear and the FSM enters IDLE; no grant is made in ACK.
REQ-026 dtr SHALL hold its value until the next read completion.
REQ-027 A channel SHALL drop req on the edge where it samples ack; keeping req high requests a new back-to-back transaction, which is granted in the following IDLE cycle.
REQ-028 done in IDLE or ACK SHALL be ignored.
REQ-029 At most one ack_ch bit SHALL be high in any cycle.

Reset
REQ-030 While reset=1 at a clock edge, the FSM SHALL enter IDLE with valid=0, ack_ch=0, err=0, addr=0, dout=0, rw=0, dtr=0, timeout counter=0 and last=NCH-1.
REQ-031 Reset during BUSY SHALL abort silently: valid=0 the next cycle and no ack is issued.

Verification
REQ-032 Single read: NCH=2; ch1 requests a read of 0x100; done is given with din=0xDEADBEEF 3 cycles after valid -> ack_ch=2'b10 for 1 cycle with dtr=0xDEADBEEF and err=0.
REQ-033 Fixed priority: RR=0; ch0 and ch1 keep req high continuously -> ch0 is granted every time and ch1 starves.
REQ-034 Round-robin: RR=1, NCH=4; all req high -> grant order 0,1,2,3,0; with only ch2 and ch0 requesting after last=2 -> ch0 is granted next.
REQ-035 Timeout: TIMEOUT=5; done never asserted -> ack with err=1 in the 6th cycle after valid rises, and dtr unchanged.
REQ-036 Write and reset: ch0 writes 0x55 to 0x8; valid rises and dout=0x55; reset is asserted before done -> valid=0 next cycle, no ack, and dtr stays 0.

Source files
------------

// File: rtl/hs32_memarb.sv
// hs32_memarb: N-channel arbiter onto a single 32-bit memory bus.
// Fixed-priority or round-robin grant, optional BUSY timeout.
module hs32_memarb #(
    parameter int NCH     = 2,
    parameter int RR      = 0,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*32-1:0] addr_ch,
    input  logic [NCH*32-1:0] dtw_ch,
    input  logic [NCH-1:0]    rw_ch,
    input  logic [NCH-1:0]    req_ch,
    output logic [NCH-1:0]    ack_ch,
    output logic [31:0]       dtr,
    output logic              err,
    output logic [31:0]       addr,
    output logic              rw,
    output logic [31:0]       dout,
    output logic              valid,
    input  logic [31:0]       din,
    input  logic              done
);

    localparam int IW = $clog2(NCH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   last, last_n;
    logic [IW-1:0]   cur, cur_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NCH-1:0]  ack_n;
    logic [31:0]     dtr_n, addr_n, dout_n;
    logic            err_n, rw_n, valid_n;

    logic [IW-1:0]   gnt;
    logic            hit;
    logic [4:0]      s;
    logic            expired;

    // Grant search: upward from last+1 in round-robin, from 0 otherwise.
    always_comb begin
        gnt = '0;
        hit = 1'b0;
        s   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (RR != 0) s = 5'(last) + 5'(k) + 5'd1;
            else         s = 5'(k);
            if (s >= 5'(NCH)) s = s - 5'(NCH);
            if (!hit && req_ch[s[IW-1:0]]) begin
                hit = 1'b1;
                gnt = s[IW-1:0];
            end
        end
    end

    assign expired = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT));

    // Next-state and next registered-output computation.
    always_comb begin
        state_n = state;
        last_n  = last;
        cur_n   = cur;
        cnt_n   = cnt;
        ack_n   = ack_ch;
        dtr_n   = dtr;
        err_n   = err;
        addr_n  = addr;
        rw_n    = rw;
        dout_n  = dout;
        valid_n = valid;
        case (state)
            IDLE: begin
                if (hit) begin
                    cur_n   = gnt;
                    last_n  = gnt;
                    addr_n  = addr_ch[32*gnt +: 32];
                    dout_n  = dtw_ch[32*gnt +: 32];
                    rw_n    = rw_ch[gnt];
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    if (!rw) dtr_n = din;
                    valid_n    = 1'b0;
                    ack_n      = '0;
                    ack_n[cur] = 1'b1;
                    err_n      = 1'b0;
                    state_n    = ACK;
                end else if (expired) begin
                    valid_n    = 1'b0;
                    ack_n      = '0;
                    ack_n[cur] = 1'b1;
                    err_n      = 1'b1;
                    state_n    = ACK;
                end else if (TIMEOUT > 0) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ACK: begin
                ack_n   = '0;
                err_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            last   <= IW'(NCH - 1);
            cur    <= '0;
            cnt    <= '0;
            ack_ch <= '0;
            dtr    <= '0;
            err    <= 1'b0;
            addr   <= '0;
            rw     <= 1'b0;
            dout   <= '0;
            valid  <= 1'b0;
        end else begin
            state  <= state_n;
            last   <= last_n;
            cur    <= cur_n;
            cnt    <= cnt_n;
            ack_ch <= ack_n;
            dtr    <= dtr_n;
            err    <= err_n;
            addr   <= addr_n;
            rw     <= rw_n;
            dout   <= dout_n;
            valid  <= valid_n;
        end
    end

endmodule

// File: tb/tb_hs32_memarb.sv
// tb_hs32_memarb: two arbiter configurations behind one stimulus set,
// checked against a transaction-level reference model.
module tb_hs32_memarb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         sel;
    logic [127:0] addr_ch, dtw_ch;
    logic [3:0]   rw_ch, req_ch;
    logic [31:0]  din;
    logic         done;

    logic [1:0]  a_ack;
    logic [31:0] a_dtr, a_addr, a_dout;
    logic        a_err, a_rw, a_valid;
    logic [3:0]  b_ack;
    logic [31:0] b_dtr, b_addr, b_dout;
    logic        b_err, b_rw, b_valid;

    hs32_memarb #(.NCH(2), .RR(0), .TIMEOUT(0)) dut_a (
        .clk(clk), .reset(reset),
        .addr_ch(addr_ch[63:0]), .dtw_ch(dtw_ch[63:0]),
        .rw_ch(rw_ch[1:0]), .req_ch(sel ? 2'b00 : req_ch[1:0]),
        .ack_ch(a_ack), .dtr(a_dtr), .err(a_err),
        .addr(a_addr), .rw(a_rw), .dout(a_dout), .valid(a_valid),
        .din(din), .done(done & ~sel)
    );

    hs32_memarb #(.NCH(4), .RR(1), .TIMEOUT(5)) dut_b (
        .clk(clk), .reset(reset),
        .addr_ch(addr_ch), .dtw_ch(dtw_ch),
        .rw_ch(rw_ch), .req_ch(sel ? req_ch : 4'b0000),
        .ack_ch(b_ack), .dtr(b_dtr), .err(b_err),
        .addr(b_addr), .rw(b_rw), .dout(b_dout), .valid(b_valid),
        .din(din), .done(done & sel)
    );

    wire [3:0]  o_ack   = sel ? b_ack : {2'b00, a_ack};
    wire [31:0] o_dtr   = sel ? b_dtr : a_dtr;
    wire [31:0] o_addr  = sel ? b_addr : a_addr;
    wire [31:0] o_dout  = sel ? b_dout : a_dout;
    wire        o_err   = sel ? b_err : a_err;
    wire        o_rw    = sel ? b_rw : a_rw;
    wire        o_valid = sel ? b_valid : a_valid;

    int          checks = 0;
    int          errors = 0;
    int          last_m [2];
    logic [31:0] dtr_m  [2];

    bit          fx_en = 0;
    logic [31:0] fx_addr, fx_dtw, fx_din;
    logic        fx_rw;

    function automatic int pick(input logic [3:0] rq);
        int n = sel ? 4 : 2;
        for (int k = 1; k <= n; k++) begin
            int i;
            i = sel ? (last_m[1] + k) % n : k - 1;
            if (rq[i]) return i;
        end
        return 0;
    endfunction

    task automatic do_reset();
        reset = 1; req_ch = 0; done = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        last_m[0] = 1; last_m[1] = 3;
        dtr_m[0] = 0;  dtr_m[1] = 0;
    endtask

    task automatic txn(input logic [3:0] rq, input int dly, input bit keep);
        int g, ca;
        bit to;
        logic [31:0] ea, ed, dr;
        logic erw;
        logic [3:0] eack;
        g = pick(rq);
        addr_ch = {$urandom, $urandom, $urandom, $urandom};
        dtw_ch  = {$urandom, $urandom, $urandom, $urandom};
        rw_ch   = 4'($urandom);
        if (fx_en) begin
            addr_ch[32*g +: 32] = fx_addr;
            dtw_ch[32*g +: 32]  = fx_dtw;
            rw_ch[g]            = fx_rw;
        end
        ea = addr_ch[32*g +: 32];
        ed = dtw_ch[32*g +: 32];
        erw = rw_ch[g];
        req_ch = rq; done = 0;
        @(posedge clk); #1;
        last_m[sel] = g;
        to = sel && (dly > 5);
        ca = to ? 6 : dly + 1;
        dr = dtr_m[sel];
        eack = 4'b0001 << g;
        for (int c = 0; c < ca; c++) begin
            checks++;
            if (o_valid !== 1'b1 || o_ack !== 4'b0 || o_addr !== ea ||
                o_rw !== erw || o_dout !== ed) begin
                errors++;
                $display("FAIL busy c=%0d valid=%b ack=%b addr=%h rw=%b dout=%h want addr=%h rw=%b dout=%h",
                         c, o_valid, o_ack, o_addr, o_rw, o_dout, ea, erw, ed);
            end
            addr_ch = {$urandom, $urandom, $urandom, $urandom};
            dtw_ch  = {$urandom, $urandom, $urandom, $urandom};
            rw_ch   = 4'($urandom);
            req_ch  = 4'($urandom);
            din  = (fx_en && c == dly) ? fx_din : $urandom;
            done = (c == dly);
            if (done && !erw) dr = din;
            @(posedge clk); #1;
        end
        checks++;
        if (o_ack !== eack || o_err !== to || o_valid !== 1'b0 || o_dtr !== dr) begin
            errors++;
            $display("FAIL ack ack=%b err=%b valid=%b dtr=%h want ack=%b err=%b dtr=%h",
                     o_ack, o_err, o_valid, o_dtr, eack, to, dr);
        end
        dtr_m[sel] = dr;
        req_ch = keep ? rq : 4'b0;
        done = 1'($urandom);
        din = $urandom;
        @(posedge clk); #1;
        checks++;
        if (o_ack !== 4'b0 || o_err !== 1'b0 || o_valid !== 1'b0 || o_dtr !== dr) begin
            errors++;
            $display("FAIL ack_len ack=%b err=%b valid=%b dtr=%h want ack=0 err=0 dtr=%h",
                     o_ack, o_err, o_valid, o_dtr, dr);
        end
        req_ch = 0; done = 0;
    endtask

    task automatic test_reset();
        reset = 1; req_ch = 4'hf; done = 1; din = 32'hffff_ffff;
        addr_ch = '1; dtw_ch = '1; rw_ch = 4'hf;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            checks++;
            if (o_valid !== 0 || o_ack !== 0 || o_err !== 0 || o_addr !== 0 ||
                o_dout !== 0 || o_rw !== 0 || o_dtr !== 0) begin
                errors++;
                $display("FAIL reset sel=%0d valid=%b ack=%b err=%b addr=%h dout=%h rw=%b dtr=%h want all 0",
                         s, o_valid, o_ack, o_err, o_addr, o_dout, o_rw, o_dtr);
            end
        end
        sel = 0;
        do_reset();
    endtask

    task automatic test_single_read();
        sel = 0;
        fx_en = 1; fx_addr = 32'h100; fx_dtw = $urandom;
        fx_rw = 0; fx_din = 32'hDEADBEEF;
        txn(4'b0010, 3, 0);
        fx_en = 0;
    endtask

    task automatic test_fixed_priority();
        sel = 0;
        repeat (4) txn(4'b0011, $urandom_range(0, 3), 1);
    endtask

    task automatic test_round_robin();
        do_reset();
        sel = 1;
        repeat (5) txn(4'b1111, $urandom_range(0, 4), 1);
        txn(4'b0100, 1, 0);
        txn(4'b0101, 2, 0);
    endtask

    task automatic test_timeout();
        sel = 1;
        fx_en = 1; fx_addr = $urandom; fx_dtw = $urandom;
        fx_rw = 0; fx_din = 32'h1234_5678;
        txn(4'b0010, 2, 0);
        fx_en = 0;
        txn(4'b1000, 100, 0);
        txn(4'b0001, 5, 0);
        txn(4'b0100, 4, 0);
    endtask

    task automatic test_write_reset();
        do_reset();
        sel = 0;
        addr_ch = '0; dtw_ch = '0;
        addr_ch[31:0] = 32'h8; dtw_ch[31:0] = 32'h55;
        rw_ch = 4'b0001; req_ch = 4'b0001;
        @(posedge clk); #1;
        checks++;
        if (o_valid !== 1 || o_dout !== 32'h55 || o_addr !== 32'h8 || o_rw !== 1) begin
            errors++;
            $display("FAIL wr_start valid=%b dout=%h addr=%h rw=%b want 1 55 8 1",
                     o_valid, o_dout, o_addr, o_rw);
        end
        reset = 1; req_ch = 0;
        @(posedge clk); #1;
        reset = 0;
        last_m[0] = 1; last_m[1] = 3;
        dtr_m[0] = 0;  dtr_m[1] = 0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (o_valid !== 0 || o_ack !== 0 || o_dtr !== 0) begin
                errors++;
                $display("FAIL wr_abort c=%0d valid=%b ack=%b dtr=%h want 0 0 0",
                         c, o_valid, o_ack, o_dtr);
            end
            done = 1; din = $urandom;
            @(posedge clk); #1;
            done = 0;
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            repeat (30) begin
                if ($urandom_range(0, 4) == 0) begin
                    req_ch = 0; done = 1; din = $urandom;
                    @(posedge clk); #1;
                    done = 0;
                    checks++;
                    if (o_valid !== 0 || o_ack !== 0 || o_dtr !== dtr_m[sel]) begin
                        errors++;
                        $display("FAIL idle_done valid=%b ack=%b dtr=%h want 0 0 %h",
                                 o_valid, o_ack, o_dtr, dtr_m[sel]);
                    end
                end else begin
                    logic [3:0] rq;
                    rq = sel ? 4'($urandom_range(1, 15)) : 4'($urandom_range(1, 3));
                    txn(rq, sel ? $urandom_range(0, 8) : $urandom_range(0, 6),
                        1'($urandom));
                end
            end
        end
    endtask

    initial begin
        sel = 0; reset = 1; done = 0; req_ch = 0; din = 0;
        addr_ch = '0; dtw_ch = '0; rw_ch = 0;
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_write_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
